// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam logic [31:0] MIN_DIV = 32'd2;

  typedef struct packed {
    logic slow;
    logic tick;
  } chan_out_t;

  // Divisors below 2 cannot produce a high and a low phase, so they are raised to MIN_DIV.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  // ceil(n/2) without the overflow that (n+1)>>1 would have at full width.
  function automatic logic [31:0] half_up(input logic [31:0] n);
    return (n >> 1) + {31'b0, n[0]};
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active divisor, pending divisor and registered outputs.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_data_i,
  output logic             slow_clk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  chan_out_t        out_q, out_d;

  logic [CNT_W-1:0] pend_nv;
  logic             pend_has;
  logic             wrap;
  logic             restart;
  logic             load;

  always_comb begin
    pend_nv  = wr_i ? wr_data_i : pend_q;
    pend_has = wr_i | pend_vld_q;
    wrap     = (cnt_q >= div_q - CNT_W'(1));
    // Disable, sync and the natural wrap all start a fresh period at cnt=0.
    restart  = ~en_i | sync_i | wrap;
    load     = restart & pend_has;

    cnt_d      = restart ? '0 : cnt_q + CNT_W'(1);
    div_d      = load ? CNT_W'(clamp_div(32'(pend_nv))) : div_q;
    pend_d     = pend_nv;
    pend_vld_d = pend_has & ~load;

    // Outputs come from next state so they line up with the cnt value they describe.
    out_d.slow = (cnt_d >= CNT_W'(half_up(32'(div_d))));
    out_d.tick = (cnt_d == div_d - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= CNT_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      out_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
    end
  end

  assign slow_clk_o = out_q.slow;
  assign tick_o     = out_q.tick;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock-enable / divided-clock generator with per-channel programmable divisors.
// Optional CLKDIV_SYNC_EN adds a sync_req input that phase-aligns all enabled channels.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int   CHANNELS    = 4,
  parameter int   CNT_W       = 16,
  parameter int   DEFAULT_DIV = 5,
  localparam int  CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                div_wr,
  input  logic [CH_W-1:0]     div_ch,
  input  logic [CNT_W-1:0]    div_data,
`ifdef CLKDIV_SYNC_EN
  input  logic                sync_req,
`endif
  output logic [CHANNELS-1:0] slow_clk,
  output logic [CHANNELS-1:0] tick
);

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_req;
`else
  assign sync = 1'b0;
`endif

  // An out-of-range div_ch matches no channel, so that write is dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr_hit;
    assign wr_hit = div_wr && (div_ch == CH_W'(i));

    clkdiv_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en[i]),
      .sync_i     (sync),
      .wr_i       (wr_hit),
      .wr_data_i  (div_data),
      .slow_clk_o (slow_clk[i]),
      .tick_o     (tick[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: a 2-channel and a 3-channel instance against a period-position model.
module tb_clkdiv_multi;

  localparam int CNT_W = 8;
  localparam int DEF   = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] en_v;
  logic       wr;
  logic [1:0] ch;
  logic [7:0] data;
`ifdef CLKDIV_SYNC_EN
  logic       sync;
`endif
  logic [1:0] slow_a, tick_a;
  logic [2:0] slow_b, tick_b;

  always #5 clk = ~clk;

  clkdiv_multi #(.CHANNELS(2), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (en_v[1:0]),
    .div_wr   (wr),
    .div_ch   (ch[0:0]),
    .div_data (data),
`ifdef CLKDIV_SYNC_EN
    .sync_req (sync),
`endif
    .slow_clk (slow_a),
    .tick     (tick_a)
  );

  clkdiv_multi #(.CHANNELS(3), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (en_v),
    .div_wr   (wr),
    .div_ch   (ch),
    .div_data (data),
`ifdef CLKDIV_SYNC_EN
    .sync_req (sync),
`endif
    .slow_clk (slow_b),
    .tick     (tick_b)
  );

  // Model slots 0..1 belong to instance A, 2..4 to instance B.
  int m_pos [5];
  int m_n   [5];
  int m_pend[5];
  bit m_pv  [5];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_total++;
    if (act === 32'(exp)) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    bit s;
`ifdef CLKDIV_SYNC_EN
    s = sync;
`else
    s = 1'b0;
`endif
    for (int k = 0; k < 5; k++) begin
      int c;
      int val;
      bit hit;
      bit has;
      c   = (k < 2) ? k : k - 2;
      hit = (k < 2) ? (wr && int'(ch[0]) == c) : (wr && int'(ch) == c);
      if (rst) begin
        m_pos[k] = 0; m_n[k] = DEF; m_pend[k] = 0; m_pv[k] = 1'b0;
      end else begin
        has = hit || m_pv[k];
        val = hit ? int'(data) : m_pend[k];
        if (!en_v[c] || s || m_pos[k] == m_n[k] - 1) begin
          m_pos[k] = 0;
          if (has) begin
            m_n[k] = (val < 2) ? 2 : val;
            has    = 1'b0;
          end
        end else begin
          m_pos[k] = m_pos[k] + 1;
        end
        m_pend[k] = val;
        m_pv[k]   = has;
      end
    end
  endtask

  function automatic int exp_slow(int k);
    return (m_pos[k] >= m_n[k] - m_n[k] / 2) ? 1 : 0;
  endfunction

  function automatic int exp_tick(int k);
    return (m_pos[k] == m_n[k] - 1) ? 1 : 0;
  endfunction

  // Advance one clock: model follows the posedge, outputs are compared at the negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k < 2) begin
        chk($sformatf("slowA%0d", k), 32'(slow_a[k]), exp_slow(k));
        chk($sformatf("tickA%0d", k), 32'(tick_a[k]), exp_tick(k));
      end else begin
        chk($sformatf("slowB%0d", k - 2), 32'(slow_b[k - 2]), exp_slow(k));
        chk($sformatf("tickB%0d", k - 2), 32'(tick_b[k - 2]), exp_tick(k));
      end
    end
  endtask

  task automatic wait_pn(input int k, input int p, input int n, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (m_pos[k] == p && (n < 0 || m_n[k] == n)) ok = 1'b1;
      else cycle();
    end
    chk(nm, 32'(ok), 1);
  endtask

  task automatic write(input int c, input int d);
    wr = 1'b1; ch = 2'(c); data = 8'(d);
    cycle();
    wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1s[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    int t1t[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int t2s0[7] = '{1, 1, 0, 0, 1, 1, 0};
    int t2t0[7] = '{0, 1, 0, 0, 0, 1, 0};
    int t2s1[7] = '{1, 1, 0, 0, 0, 1, 1};
    int t2t1[7] = '{0, 1, 0, 0, 0, 0, 1};
    int t3s2[4] = '{0, 1, 0, 1};
    int t3s3[6] = '{0, 0, 1, 0, 0, 1};
    int t4s[6]  = '{0, 0, 0, 1, 1, 0};
    int t4t[6]  = '{0, 0, 0, 0, 1, 0};
    int t5s[3]  = '{0, 0, 1};

    rst = 1'b1; en_v = 3'b111; wr = 1'b0; ch = 2'd0; data = 8'd0;
`ifdef CLKDIV_SYNC_EN
    sync = 1'b0;
`endif
    for (int k = 0; k < 5; k++) begin
      m_pos[k] = 0; m_n[k] = DEF; m_pend[k] = 0; m_pv[k] = 1'b0;
    end

    // Reset, then the default divide-by-5 waveform on every channel.
    cycle();
    cycle();
    chk("rst_slowA", 32'(slow_a), 0);
    chk("rst_tickA", 32'(tick_a), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cycle();
      chk("div5_slowA0", 32'(slow_a[0]), t1s[i]);
      chk("div5_tickA0", 32'(tick_a[0]), t1t[i]);
      chk("div5_slowB2", 32'(slow_b[2]), t1s[i]);
    end

    // Mid-period write to ch0: period finishes at 5, then runs at 4; ch1 stays at 5.
    wait_pn(0, 2, -1, "wait_t2");
    write(0, 4);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) cycle();
      chk("wr4_slowA0", 32'(slow_a[0]), t2s0[i]);
      chk("wr4_tickA0", 32'(tick_a[0]), t2t0[i]);
      chk("wr4_slowA1", 32'(slow_a[1]), t2s1[i]);
      chk("wr4_tickA1", 32'(tick_a[1]), t2t1[i]);
    end

    // Divisors 0 and 1 clamp to 2; then 3 gives 2 low / 1 high.
    write(1, 0);
    write(1, 1);
    wait_pn(1, 0, 2, "wait_n2");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle();
      chk("n2_slowA1", 32'(slow_a[1]), t3s2[i]);
      chk("n2_tickA1", 32'(tick_a[1]), t3s2[i]);
    end
    write(1, 3);
    wait_pn(1, 0, 3, "wait_n3");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cycle();
      chk("n3_slowA1", 32'(slow_a[1]), t3s3[i]);
      chk("n3_tickA1", 32'(tick_a[1]), t3s3[i]);
    end

    // Drop en mid-period, reprogram 5 while idle, re-enable for a full period.
    wait_pn(0, 2, -1, "wait_t4");
    en_v[0] = 1'b0;
    cycle();
    chk("dis_slowA0", 32'(slow_a[0]), 0);
    chk("dis_tickA0", 32'(tick_a[0]), 0);
    write(0, 5);
    cycle();
    en_v[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cycle();
      chk("reen_slowA0", 32'(slow_a[0]), t4s[i]);
      chk("reen_tickA0", 32'(tick_a[0]), t4t[i]);
    end

    // Out-of-range channel write, then a write landing exactly on the wrap.
    write(3, 2);
    for (int i = 0; i < 6; i++) cycle();
    wait_pn(0, 4, 5, "wait_t5");
    write(0, 3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycle();
      chk("wrapwr_slowA0", 32'(slow_a[0]), t5s[i]);
      chk("wrapwr_tickA0", 32'(tick_a[0]), t5s[i]);
    end

`ifdef CLKDIV_SYNC_EN
    write(0, 4);
    write(1, 6);
    for (int i = 0; i < 20; i++) cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    chk("sync_pos0", 32'(slow_a), 0);
    for (int i = 1; i < 24; i++) begin
      cycle();
      if (i == 5)  chk("sync_tick5", 32'(tick_a), 2);
      if (i == 11) chk("sync_tick11", 32'(tick_a), 3);
      if (i == 23) chk("sync_tick23", 32'(tick_a), 3);
    end
    rst = 1'b1; sync = 1'b1;
    cycle();
    rst = 1'b0; sync = 1'b0;
    chk("rstsync_slowB", 32'(slow_b), 0);
    chk("rstsync_tickB", 32'(tick_b), 0);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 3; b++) en_v[b] = ($urandom_range(7) != 0);
      wr   = ($urandom_range(3) == 0);
      ch   = 2'($urandom_range(3));
      data = 8'($urandom_range(9));
      rst  = ($urandom_range(99) == 0);
`ifdef CLKDIV_SYNC_EN
      sync = ($urandom_range(29) == 0);
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
